// File: rtl/tim_seq_ctrl.sv
// Purpose : CPU bus slave that sequences the simple timer (prescaler, period, pulse FIFO)
//           by mastering the timer's Write/Addr/WData register port.
// Latency : every timer write is a single registered cycle; a pulse update reaches the timer
//           two clk edges after tim_counter first shows the wrapped value.
// Backpressure: none; a push into a full FIFO is dropped and flagged as overflow, and a wrap
//           with an empty FIFO is flagged as underrun.
// Ports   : clk, rst (async active-low); CPU side Write/Addr/WData/RData;
//           timer side tim_Write/tim_Addr/tim_WData (outputs) and tim_counter (input).
module tim_seq_ctrl #(
  parameter int MEMORY_TYPE = 0,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  Write,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  output logic [31:0] RData,
  output logic [3:0]  tim_Write,
  output logic [31:0] tim_Addr,
  output logic [31:0] tim_WData,
  input  logic [31:0] tim_counter
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  localparam logic [31:0] TIM_PSC  = 32'h0000_0000;
  localparam logic [31:0] TIM_MODE = 32'h0000_0004;
  localparam logic [31:0] TIM_ARR  = 32'h0000_0008;
  localparam logic [31:0] TIM_CCR  = 32'h0000_000C;
  // enable + ARR preload + up-count
  localparam logic [31:0] MODE_RUN = 32'h0000_000C;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CFG_PSC  = 3'd1,
    S_CFG_ARR  = 3'd2,
    S_CFG_CCR  = 3'd3,
    S_CFG_MODE = 3'd4,
    S_RUN      = 3'd5,
    S_WR_CCR   = 3'd6,
    S_STOP     = 3'd7
  } state_t;

  state_t           r_state;
  logic [31:0]      r_psc;
  logic [31:0]      r_arr;
  logic             r_soe;
  logic             r_underrun;
  logic             r_overflow;
  logic [31:0]      r_upd_cnt;
  logic [31:0]      r_prev_cnt;
  logic [3:0]       r_tim_write;
  logic [31:0]      r_tim_addr;
  logic [31:0]      r_tim_wdata;

  logic [31:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_count;

  logic [2:0]       w_sel;
  logic             w_ctrl_wr;
  logic             w_start;
  logic             w_stop;
  logic             w_empty;
  logic             w_full;
  logic             w_busy;
  logic             w_wrap;
  logic             w_pop;
  logic             w_upd;
  logic             w_push_req;
  logic             w_push;
  logic             w_ovf_set;
  logic             w_unr_set;
  logic             w_sts_clr;
  logic [31:0]      w_head;
  logic [31:0]      w_status;
  logic [31:0]      w_rdata;
  logic             w_unused;

  assign w_sel      = Addr[4:2];
  assign w_unused   = ^{Addr[31:5], Addr[1:0]};
  assign w_ctrl_wr  = (w_sel == 3'd0) && Write[0];
  assign w_start    = w_ctrl_wr && WData[0];
  assign w_stop     = w_ctrl_wr && WData[1];
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == LW'(FIFO_DEPTH));
  assign w_busy     = (r_state != S_IDLE);
  assign w_wrap     = (r_state == S_RUN) && (tim_counter < r_prev_cnt);
  assign w_head     = r_mem[r_rptr];

  // A pending stop pre-empts the pop that the next write step would have done.
  assign w_upd      = w_wrap && !w_empty && !w_stop;
  assign w_pop      = ((r_state == S_CFG_ARR) && !w_empty && !w_stop) || w_upd;

  assign w_push_req = (w_sel == 3'd3) && (|Write);
  // A simultaneous pop frees the slot, so a push at full still lands.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_ovf_set  = w_push_req && w_full && !w_pop;
  assign w_unr_set  = ((r_state == S_IDLE) && w_start && w_empty) || (w_wrap && w_empty);
  assign w_sts_clr  = (w_sel == 3'd4) && Write[0];

  assign tim_Write  = r_tim_write;
  assign tim_Addr   = r_tim_addr;
  assign tim_WData  = r_tim_wdata;

  // Pulse FIFO storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= WData;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // CPU-visible configuration and flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_psc      <= '0;
      r_arr      <= '0;
      r_soe      <= 1'b0;
      r_underrun <= 1'b0;
      r_overflow <= 1'b0;
      r_upd_cnt  <= '0;
      r_prev_cnt <= '0;
    end else begin
      r_prev_cnt <= tim_counter;
      for (int b = 0; b < 4; b++) begin
        if ((w_sel == 3'd1) && Write[b]) r_psc[8*b +: 8] <= WData[8*b +: 8];
        if ((w_sel == 3'd2) && Write[b]) r_arr[8*b +: 8] <= WData[8*b +: 8];
      end
      if (w_ctrl_wr) r_soe <= WData[2];
      // Set beats clear when both land in the same cycle.
      if (w_unr_set)                   r_underrun <= 1'b1;
      else if (w_sts_clr && WData[3])  r_underrun <= 1'b0;
      if (w_ovf_set)                   r_overflow <= 1'b1;
      else if (w_sts_clr && WData[4])  r_overflow <= 1'b0;
      if (w_upd) r_upd_cnt <= r_upd_cnt + 32'd1;
    end
  end

  // Sequencer. Timer bus outputs are registered on the transition into each
  // write state so they are stable for exactly that state's single cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_tim_write <= 4'h0;
      r_tim_addr  <= '0;
      r_tim_wdata <= '0;
    end else begin
      {r_tim_write, r_tim_addr, r_tim_wdata} <= {4'h0, 32'h0, 32'h0};
      case (r_state)
        S_IDLE: begin
          if (w_start && !w_empty) begin
            r_state <= S_CFG_PSC;
            {r_tim_write, r_tim_addr, r_tim_wdata} <= {4'hF, TIM_PSC, r_psc};
          end
        end
        S_CFG_PSC: begin
          if (w_stop) begin
            r_state <= S_STOP;
            {r_tim_write, r_tim_addr, r_tim_wdata} <= {4'hF, TIM_MODE, 32'h0};
          end else begin
            r_state <= S_CFG_ARR;
            {r_tim_write, r_tim_addr, r_tim_wdata} <= {4'hF, TIM_ARR, r_arr};
          end
        end
        S_CFG_ARR: begin
          if (w_stop) begin
            r_state <= S_STOP;
            {r_tim_write, r_tim_addr, r_tim_wdata} <= {4'hF, TIM_MODE, 32'h0};
          end else begin
            r_state <= S_CFG_CCR;
            {r_tim_write, r_tim_addr, r_tim_wdata} <= {4'hF, TIM_CCR, w_head};
          end
        end
        S_CFG_CCR: begin
          if (w_stop) begin
            r_state <= S_STOP;
            {r_tim_write, r_tim_addr, r_tim_wdata} <= {4'hF, TIM_MODE, 32'h0};
          end else begin
            r_state <= S_CFG_MODE;
            {r_tim_write, r_tim_addr, r_tim_wdata} <= {4'hF, TIM_MODE, MODE_RUN};
          end
        end
        S_CFG_MODE, S_WR_CCR: begin
          if (w_stop) begin
            r_state <= S_STOP;
            {r_tim_write, r_tim_addr, r_tim_wdata} <= {4'hF, TIM_MODE, 32'h0};
          end else begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_stop) begin
            r_state <= S_STOP;
            {r_tim_write, r_tim_addr, r_tim_wdata} <= {4'hF, TIM_MODE, 32'h0};
          end else if (w_wrap) begin
            if (!w_empty) begin
              r_state <= S_WR_CCR;
              {r_tim_write, r_tim_addr, r_tim_wdata} <= {4'hF, TIM_CCR, w_head};
            end else if (r_soe) begin
              r_state <= S_STOP;
              {r_tim_write, r_tim_addr, r_tim_wdata} <= {4'hF, TIM_MODE, 32'h0};
            end
          end
        end
        S_STOP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_status          = '0;
    w_status[0]       = w_busy;
    w_status[1]       = w_full;
    w_status[2]       = w_empty;
    w_status[3]       = r_underrun;
    w_status[4]       = r_overflow;
    w_status[8 +: LW] = r_count;
  end

  always_comb begin
    w_rdata = '0;
    case (w_sel)
      3'd0:    w_rdata = {29'd0, r_soe, 2'b00};
      3'd1:    w_rdata = r_psc;
      3'd2:    w_rdata = r_arr;
      3'd4:    w_rdata = w_status;
      3'd5:    w_rdata = r_upd_cnt;
      default: w_rdata = '0;
    endcase
  end

  generate
    if (MEMORY_TYPE == 1) begin : g_rd_reg
      logic [31:0] r_rdata;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_rdata <= '0;
        else      r_rdata <= w_rdata;
      end
      assign RData = r_rdata;
    end else begin : g_rd_comb
      assign RData = w_rdata;
    end
  endgenerate

endmodule

// File: doc/tim_seq_ctrl.md
Name: tim_seq_ctrl

Overview:
Bus-slave duty-cycle sequencer that drives the simple timer peripheral as a bus master on the timer's register interface. The CPU loads prescaler, period and a FIFO of compare (pulse) values, then issues start. The block configures the timer, enables it in up-count mode, and writes the next FIFO entry to the timer's pulse register on every counter wrap. It sits between the CPU peripheral bus and the timer's Write/Addr/WData port.

Parameters:
MEMORY_TYPE, 0, 0 = combinational RData; 1 = RData registered on clk (one-cycle read latency).
FIFO_DEPTH, 8, pulse FIFO entries; power of 2, at least 2. LW = clog2(FIFO_DEPTH)+1.

Ports:
clk  in  1  clock.
rst  in  1  reset, asynchronous, active-low.
Write  in  4  CPU byte write enables.
Addr  in  32  CPU address; Addr[4:2] selects the register.
WData  in  32  CPU write data.
RData  out  32  CPU read data.
tim_Write  out  4  timer byte enables; 4'hF during a write cycle, else 0.
tim_Addr  out  32  timer register address.
tim_WData  out  32  timer write data.
tim_counter  in  32  timer current counter value (out_counter).

Behaviour:
- Registers selected by Addr[4:2]:
  - 0 CTRL: write-only.
    - bit0 start, one-shot.
    - bit1 stop, one-shot.
    - bit2 stop_on_empty, stored.
    - Acts only when Write[0]=1. Reads return {29'd0, stop_on_empty, 2'b0}.
  - 1 PSC, 2 ARR: R/W with per-byte enables.
  - 3 PUSH: write only.
    - Any Write!=0 pushes the full WData.
    - Push while full: entry dropped, overflow flag set.
    - Reads return 0.
  - 4 STATUS:
    - bit0 busy, bit1 full, bit2 empty, bit3 underrun, bit4 overflow, bits[8+LW-1:8] FIFO level.
    - Writing 1 to bit3 or bit4 (with Write[0]=1) clears that flag.
    - If a set and a clear hit the same cycle, set wins.
  - 5 UPD_CNT: read-only count of pulse updates written; 32-bit, wraps.
  - 6, 7: read 0.
- Reset (rst=0, asynchronous): all registers, the FIFO and UPD_CNT clear. State = IDLE. tim_Write, tim_Addr, tim_WData and RData are 0.
- FSM: IDLE, CFG_PSC, CFG_ARR, CFG_CCR, CFG_MODE, RUN, WR_CCR, STOP.
  - Each CFG_*, WR_CCR and STOP state lasts exactly one cycle, with tim_Write=4'hF and the listed Addr/WData:
    - CFG_PSC: Addr 0x00, WData = PSC.
    - CFG_ARR: Addr 0x08, WData = ARR.
    - CFG_CCR: Addr 0x0C, WData = FIFO head, popped.
    - CFG_MODE: Addr 0x04, WData = 0x0000000C (enable, ARR preload, up-count).
    - WR_CCR: Addr 0x0C, WData = FIFO head, popped; UPD_CNT++.
    - STOP: Addr 0x04, WData = 0.
  - In all other states tim_Write=0 and tim_Addr/tim_WData are 0.
- IDLE + start:
  - FIFO non-empty: go to CFG_PSC, then CFG_ARR → CFG_CCR → CFG_MODE → RUN.
  - FIFO empty: start ignored, underrun set.
  - start while not IDLE: ignored.
- busy = (state != IDLE).
- Wrap detection:
  - prev_cnt <= tim_counter every cycle (reset value 0).
  - wrap = (tim_counter < prev_cnt), evaluated in RUN only.
- RUN + wrap:
  - FIFO non-empty: go to WR_CCR. The new pulse reaches the timer 2 clk edges after tim_counter first shows the wrapped value.
  - FIFO empty: underrun set, no write. If stop_on_empty=1 go to STOP, else stay in RUN and the timer keeps its last pulse.
- stop: accepted in any non-IDLE state. The current one-cycle write completes, then the next state is STOP; remaining CFG steps are skipped. STOP → IDLE. The FIFO is not flushed.
- FIFO push and pop in the same cycle: both succeed even when full; level is unchanged, overflow is not set.
- Only up-count mode is supported.
- PSC must be ≥1 so the WR_CCR latency is shorter than one timer tick. PSC=0 is legal but the first count after a wrap uses the old pulse.

Test Plan:
- Reset: drive rst=0 mid-RUN → tim_Write=0 and busy=0 immediately; after release STATUS reads 0x00000004.
- Config: PSC=1, ARR=9, push 3,5,7, CTRL=1 → four consecutive write cycles (0x00/1, 0x08/9, 0x0C/3, 0x04/0xC), then busy=1, level=2.
- Update: tim_counter 9→0 → the following cycle writes 0x0C/5 and UPD_CNT=1; next 9→0 writes 0x0C/7, level=0, empty=1.
- Underrun: next wrap with stop_on_empty=0 → no write, underrun=1, busy=1. Repeat with stop_on_empty=1 → write 0x04/0, busy=0 one cycle later. STATUS write 0x8 clears underrun.
- Overflow: push 9 values at depth 8 → level=8, full=1, overflow=1, 9th value never emitted. Push and pop in the same cycle at full → level stays 8, overflow not set.
- Stop mid-config: CTRL=2 during CFG_ARR → ARR write completes, next cycle 0x04/0, then IDLE. The FIFO keeps all entries and 0x0C is never written.
